// File: rtl/tx_hp_addr_table_pkg.sv
// Shared TLP encodings, default register offsets and decode helpers for the TX huge-page table.
package tx_hp_addr_table_pkg;

  localparam logic [6:0] MEM_RD32 = 7'b00_00000;
  localparam logic [6:0] MEM_RD64 = 7'b01_00000;
  localparam logic [6:0] MEM_WR32 = 7'b10_00000;
  localparam logic [6:0] MEM_WR64 = 7'b11_00000;

  localparam int DEF_ADDR_BASE_DW   = 32;
  localparam int DEF_UNLOCK_BASE_DW = 40;
  localparam int DEF_CPL_ADDR_DW    = 44;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_A32,
    ST_A64,
    ST_DATA,
    ST_DRAIN
  } sniff_state_e;

  typedef enum logic [1:0] {
    TGT_NONE,
    TGT_ADDR,
    TGT_UNLOCK,
    TGT_CPL
  } tgt_kind_e;

  typedef struct packed {
    tgt_kind_e  kind;
    logic [1:0] page;
  } tgt_t;

  // Address registers hit only on their first DW; pages beyond num_pages are misses.
  function automatic tgt_t decode_dw(input logic [5:0] dw, input int num_pages,
                                     input int addr_base, input int unlock_base,
                                     input int cpl_dw);
    tgt_t t;
    int   d;
    t.kind = TGT_NONE;
    t.page = 2'd0;
    d      = int'(dw);
    for (int i = 0; i < 4; i++) begin
      if (i < num_pages) begin
        if (d == addr_base + 2 * i) begin
          t.kind = TGT_ADDR;
          t.page = 2'(i);
        end
        if (d == unlock_base + i) begin
          t.kind = TGT_UNLOCK;
          t.page = 2'(i);
        end
      end
    end
    if (d == cpl_dw) t.kind = TGT_CPL;
    return t;
  endfunction

  function automatic logic [31:0] swap_dw(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/tx_hp_addr_table_trn_mwr_sniffer.sv
// Follows MWr TLPs on the TRN RX stream and emits a one-cycle register-write pulse on the final beat.
// Handshake: a beat transfers only when src_rdy_n and dst_rdy_n are both low; discontinue aborts the TLP.
module trn_mwr_sniffer
  import tx_hp_addr_table_pkg::*;
#(
  parameter int NUM_PAGES      = 2,
  parameter int BAR_IDX        = 2,
  parameter int ADDR_BASE_DW   = DEF_ADDR_BASE_DW,
  parameter int UNLOCK_BASE_DW = DEF_UNLOCK_BASE_DW,
  parameter int CPL_ADDR_DW    = DEF_CPL_ADDR_DW
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [63:0]  trn_rd_i,
  input  logic         trn_rsof_n_i,
  input  logic         trn_reof_n_i,
  input  logic         trn_rsrc_rdy_n_i,
  input  logic         trn_rsrc_dsc_n_i,
  input  logic [6:0]   trn_rbar_hit_n_i,
  input  logic         trn_rdst_rdy_n_i,
  output logic         wr_valid_o,
  output logic [5:0]   wr_dw_addr_o,
  output logic [63:0]  wr_data_o,
  output sniff_state_e state_o
);

  sniff_state_e state_q, state_d;
  logic         is_4dw_q, is_4dw_d;
  logic [5:0]   addr_q, addr_d;
  logic [31:0]  dw0_q, dw0_d;

  logic         beat;
  sniff_state_e end_state;
  tgt_t         tgt32, tgt64;

  assign beat      = !trn_rsrc_rdy_n_i && !trn_rdst_rdy_n_i;
  assign end_state = trn_reof_n_i ? ST_DRAIN : ST_IDLE;
  assign tgt32     = decode_dw(trn_rd_i[39:34], NUM_PAGES, ADDR_BASE_DW, UNLOCK_BASE_DW, CPL_ADDR_DW);
  assign tgt64     = decode_dw(trn_rd_i[7:2], NUM_PAGES, ADDR_BASE_DW, UNLOCK_BASE_DW, CPL_ADDR_DW);
  assign state_o   = state_q;

  always_comb begin
    state_d      = state_q;
    is_4dw_d     = is_4dw_q;
    addr_d       = addr_q;
    dw0_d        = dw0_q;
    wr_valid_o   = 1'b0;
    wr_dw_addr_o = addr_q;
    wr_data_o    = {32'h0, dw0_q};
    if (beat) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!trn_rsof_n_i) begin
            if (!trn_rbar_hit_n_i[BAR_IDX] && trn_rd_i[62:56] == MEM_WR32) begin
              state_d  = ST_A32;
              is_4dw_d = 1'b0;
            end else if (!trn_rbar_hit_n_i[BAR_IDX] && trn_rd_i[62:56] == MEM_WR64) begin
              state_d  = ST_A64;
              is_4dw_d = 1'b1;
            end else begin
              state_d = end_state;
            end
          end
        end
        ST_A32: begin
          addr_d = trn_rd_i[39:34];
          dw0_d  = swap_dw(trn_rd_i[31:0]);
          if (tgt32.kind == TGT_UNLOCK) begin
            wr_valid_o   = 1'b1;
            wr_dw_addr_o = trn_rd_i[39:34];
            wr_data_o    = {32'h0, swap_dw(trn_rd_i[31:0])};
            state_d      = end_state;
          end else if (tgt32.kind != TGT_NONE && trn_reof_n_i) begin
            state_d = ST_DATA;
          end else begin
            state_d = end_state;
          end
        end
        ST_A64: begin
          addr_d  = trn_rd_i[7:2];
          state_d = (tgt64.kind != TGT_NONE && trn_reof_n_i) ? ST_DATA : end_state;
        end
        ST_DATA: begin
          wr_valid_o = 1'b1;
          wr_data_o  = is_4dw_q ? {swap_dw(trn_rd_i[31:0]), swap_dw(trn_rd_i[63:32])}
                                : {swap_dw(trn_rd_i[63:32]), dw0_q};
          state_d    = end_state;
        end
        ST_DRAIN: if (!trn_reof_n_i) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
    // Discontinue wins over everything, including a commit on this very beat.
    if (!trn_rsrc_dsc_n_i) begin
      state_d    = ST_IDLE;
      wr_valid_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      is_4dw_q <= 1'b0;
      addr_q   <= 6'd0;
      dw0_q    <= 32'h0;
    end else begin
      state_q  <= state_d;
      is_4dw_q <= is_4dw_d;
      addr_q   <= addr_d;
      dw0_q    <= dw0_d;
    end
  end

endmodule

// File: rtl/tx_hp_addr_table.sv
// Huge-page address/qword/ready table written by host MWr TLPs and released by the TX DMA engine.
module tx_hp_addr_table
  import tx_hp_addr_table_pkg::*;
#(
  parameter int NUM_PAGES      = 2,
  parameter int BAR_IDX        = 2,
  parameter int ADDR_BASE_DW   = DEF_ADDR_BASE_DW,
  parameter int UNLOCK_BASE_DW = DEF_UNLOCK_BASE_DW,
  parameter int CPL_ADDR_DW    = DEF_CPL_ADDR_DW
) (
  input  logic                    trn_clk,
  input  logic                    reset_n,
  input  logic [63:0]             trn_rd,
  input  logic [7:0]              trn_rrem_n,
  input  logic                    trn_rsof_n,
  input  logic                    trn_reof_n,
  input  logic                    trn_rsrc_rdy_n,
  input  logic                    trn_rsrc_dsc_n,
  input  logic [6:0]              trn_rbar_hit_n,
  input  logic                    trn_rdst_rdy_n,
  output logic [NUM_PAGES*64-1:0] hp_addr,
  output logic [NUM_PAGES*32-1:0] hp_qwords,
  output logic [NUM_PAGES-1:0]    hp_ready,
  input  logic [NUM_PAGES-1:0]    hp_free,
  output logic [63:0]             completed_buffer_address,
  output logic [15:0]             unlock_overrun_cnt
);

  logic         wr_valid;
  logic [5:0]   wr_dw_addr;
  logic [63:0]  wr_data;
  sniff_state_e sniff_state;
  tgt_t         tgt;
  logic         unused_sinks;

  logic [NUM_PAGES*64-1:0] hp_addr_q, hp_addr_d;
  logic [NUM_PAGES*32-1:0] hp_qwords_q, hp_qwords_d;
  logic [NUM_PAGES-1:0]    hp_ready_q, hp_ready_d;
  logic [63:0]             cpl_addr_q, cpl_addr_d;
  logic [15:0]             overrun_q, overrun_d;

  trn_mwr_sniffer #(
    .NUM_PAGES     (NUM_PAGES),
    .BAR_IDX       (BAR_IDX),
    .ADDR_BASE_DW  (ADDR_BASE_DW),
    .UNLOCK_BASE_DW(UNLOCK_BASE_DW),
    .CPL_ADDR_DW   (CPL_ADDR_DW)
  ) u_sniffer (
    .clk_i           (trn_clk),
    .rst_n_i         (reset_n),
    .trn_rd_i        (trn_rd),
    .trn_rsof_n_i    (trn_rsof_n),
    .trn_reof_n_i    (trn_reof_n),
    .trn_rsrc_rdy_n_i(trn_rsrc_rdy_n),
    .trn_rsrc_dsc_n_i(trn_rsrc_dsc_n),
    .trn_rbar_hit_n_i(trn_rbar_hit_n),
    .trn_rdst_rdy_n_i(trn_rdst_rdy_n),
    .wr_valid_o      (wr_valid),
    .wr_dw_addr_o    (wr_dw_addr),
    .wr_data_o       (wr_data),
    .state_o         (sniff_state)
  );

  assign unused_sinks = ^{trn_rrem_n, sniff_state};
  assign tgt = decode_dw(wr_dw_addr, NUM_PAGES, ADDR_BASE_DW, UNLOCK_BASE_DW, CPL_ADDR_DW);

  always_comb begin
    hp_addr_d   = hp_addr_q;
    hp_qwords_d = hp_qwords_q;
    hp_ready_d  = hp_ready_q;
    cpl_addr_d  = cpl_addr_q;
    overrun_d   = overrun_q;
    for (int i = 0; i < NUM_PAGES; i++) begin
      if (wr_valid && tgt.kind == TGT_UNLOCK && int'(tgt.page) == i) begin
        // Unlock beats a same-cycle free; re-unlocking a held page is an overrun.
        hp_qwords_d[32*i +: 32] = wr_data[31:0];
        hp_ready_d[i]           = 1'b1;
        if (hp_ready_q[i] && overrun_d != 16'hFFFF) overrun_d = overrun_d + 16'd1;
      end else if (hp_free[i]) begin
        hp_ready_d[i] = 1'b0;
      end
      if (wr_valid && tgt.kind == TGT_ADDR && int'(tgt.page) == i) hp_addr_d[64*i +: 64] = wr_data;
    end
    if (wr_valid && tgt.kind == TGT_CPL) cpl_addr_d = wr_data;
  end

  always_ff @(posedge trn_clk) begin
    if (!reset_n) begin
      hp_addr_q   <= '0;
      hp_qwords_q <= '0;
      hp_ready_q  <= '0;
      cpl_addr_q  <= 64'h0;
      overrun_q   <= 16'h0;
    end else begin
      hp_addr_q   <= hp_addr_d;
      hp_qwords_q <= hp_qwords_d;
      hp_ready_q  <= hp_ready_d;
      cpl_addr_q  <= cpl_addr_d;
      overrun_q   <= overrun_d;
    end
  end

  assign hp_addr                  = hp_addr_q;
  assign hp_qwords                = hp_qwords_q;
  assign hp_ready                 = hp_ready_q;
  assign completed_buffer_address = cpl_addr_q;
  assign unlock_overrun_cnt       = overrun_q;

endmodule

// File: tb/tb_tx_hp_addr_table.sv
// Directed bench for tx_hp_addr_table with default parameters (2 pages, BAR 2).
module tb_tx_hp_addr_table;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [63:0]  trn_rd;
  logic [7:0]   trn_rrem_n;
  logic         trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rsrc_dsc_n, trn_rdst_rdy_n;
  logic [6:0]   trn_rbar_hit_n;
  logic [127:0] hp_addr;
  logic [63:0]  hp_qwords;
  logic [1:0]   hp_ready;
  logic [1:0]   hp_free;
  logic [63:0]  completed_buffer_address;
  logic [15:0]  unlock_overrun_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  tx_hp_addr_table dut (
    .trn_clk                 (clk),
    .reset_n                 (reset_n),
    .trn_rd                  (trn_rd),
    .trn_rrem_n              (trn_rrem_n),
    .trn_rsof_n              (trn_rsof_n),
    .trn_reof_n              (trn_reof_n),
    .trn_rsrc_rdy_n          (trn_rsrc_rdy_n),
    .trn_rsrc_dsc_n          (trn_rsrc_dsc_n),
    .trn_rbar_hit_n          (trn_rbar_hit_n),
    .trn_rdst_rdy_n          (trn_rdst_rdy_n),
    .hp_addr                 (hp_addr),
    .hp_qwords               (hp_qwords),
    .hp_ready                (hp_ready),
    .hp_free                 (hp_free),
    .completed_buffer_address(completed_buffer_address),
    .unlock_overrun_cnt      (unlock_overrun_cnt)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One transferred beat; returns 1 time unit after the capturing edge with the bus idle again.
  task automatic beat(input logic [63:0] d, input logic sof, input logic eof, input logic dsc);
    trn_rd         = d;
    trn_rsof_n     = !sof;
    trn_reof_n     = !eof;
    trn_rsrc_dsc_n = !dsc;
    trn_rsrc_rdy_n = 1'b0;
    @(posedge clk);
    #1;
    trn_rsrc_rdy_n = 1'b1;
    trn_rsof_n     = 1'b1;
    trn_reof_n     = 1'b1;
    trn_rsrc_dsc_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic free_pulse(input logic [1:0] m);
    hp_free = m;
    @(posedge clk);
    #1;
    hp_free = 2'b00;
  endtask

  localparam logic [63:0] HDR3 = 64'h4000_0002_0000_00FF;
  localparam logic [63:0] HDR3_1 = 64'h4000_0001_0000_000F;
  localparam logic [63:0] HDR4 = 64'h6000_0002_0000_00FF;
  localparam logic [63:0] HDR4_1 = 64'h6000_0001_0000_000F;

  initial begin
    reset_n        = 1'b0;
    trn_rd         = 64'h0;
    trn_rrem_n     = 8'h00;
    trn_rsof_n     = 1'b1;
    trn_reof_n     = 1'b1;
    trn_rsrc_rdy_n = 1'b1;
    trn_rsrc_dsc_n = 1'b1;
    trn_rdst_rdy_n = 1'b0;
    trn_rbar_hit_n = 7'b111_1011;
    hp_free        = 2'b00;
    idle(3);
    reset_n = 1'b1;
    idle(1);

    check("reset_addr", hp_addr, 128'h0);
    check("reset_qwords", {64'h0, hp_qwords}, 128'h0);
    check("reset_ready", {126'h0, hp_ready}, 128'h0);
    check("reset_cpl", {64'h0, completed_buffer_address}, 128'h0);
    check("reset_cnt", {112'h0, unlock_overrun_cnt}, 128'h0);

    // 3DW address write, page 0
    beat(HDR3, 1, 0, 0);
    beat(64'hF000_0080_4433_2211, 0, 0, 0);
    check("a32_mid_addr", hp_addr, 128'h0);
    beat(64'h8877_6655_0000_0000, 0, 1, 0);
    check("a32_addr0", hp_addr, {64'h0, 64'h5566_7788_1122_3344});
    check("a32_ready", {126'h0, hp_ready}, 128'h0);

    // 4DW unlock, page 1
    beat(HDR4_1, 1, 0, 0);
    beat(64'h0000_0000_0000_00A4, 0, 0, 0);
    check("a64_ready_before", {126'h0, hp_ready}, 128'h0);
    beat(64'h0010_0000_0000_0000, 0, 1, 0);
    check("a64_qwords1", {64'h0, hp_qwords}, {64'h0, 64'h0000_1000_0000_0000});
    check("a64_ready1", {126'h0, hp_ready}, {126'h0, 2'b10});

    // Unlock page 0 three times, third with a same-cycle free
    beat(HDR3_1, 1, 0, 0);
    beat(64'hF000_00A0_1000_0000, 0, 1, 0);
    check("unl1_ready", {126'h0, hp_ready}, {126'h0, 2'b11});
    check("unl1_cnt", {112'h0, unlock_overrun_cnt}, 128'h0);
    check("unl1_qw0", {64'h0, hp_qwords}, {64'h0, 64'h0000_1000_0000_0010});
    beat(HDR3_1, 1, 0, 0);
    beat(64'hF000_00A0_2000_0000, 0, 1, 0);
    check("unl2_cnt", {112'h0, unlock_overrun_cnt}, {112'h0, 16'd1});
    beat(HDR3_1, 1, 0, 0);
    hp_free = 2'b01;
    beat(64'hF000_00A0_3000_0000, 0, 1, 0);
    hp_free = 2'b00;
    check("unl3_ready", {126'h0, hp_ready}, {126'h0, 2'b11});
    check("unl3_cnt", {112'h0, unlock_overrun_cnt}, {112'h0, 16'd2});
    check("unl3_qw0", {64'h0, hp_qwords}, {64'h0, 64'h0000_1000_0000_0030});
    free_pulse(2'b01);
    check("free0", {126'h0, hp_ready}, {126'h0, 2'b10});
    free_pulse(2'b10);
    check("free1", {126'h0, hp_ready}, 128'h0);

    // Page 2 does not exist; completion address does
    beat(HDR3, 1, 0, 0);
    beat(64'hF000_0090_AAAA_AAAA, 0, 0, 0);
    beat(64'hBBBB_BBBB_0000_0000, 0, 1, 0);
    check("oob_addr", hp_addr, {64'h0, 64'h5566_7788_1122_3344});
    beat(HDR3, 1, 0, 0);
    beat(64'hF000_00B0_0123_4567, 0, 0, 0);
    beat(64'h89AB_CDEF_0000_0000, 0, 1, 0);
    check("cpl_addr", {64'h0, completed_buffer_address}, {64'h0, 64'hEFCD_AB89_6745_2301});
    check("cpl_hp_addr", hp_addr, {64'h0, 64'h5566_7788_1122_3344});
    check("cpl_qwords", {64'h0, hp_qwords}, {64'h0, 64'h0000_1000_0000_0030});

    // Discontinue on the data beat, then a normal 4DW write to page 1
    beat(HDR4, 1, 0, 0);
    beat(64'h0000_0000_0000_0080, 0, 0, 0);
    beat(64'h1111_2222_3333_4444, 0, 1, 1);
    check("dsc_addr", hp_addr, {64'h0, 64'h5566_7788_1122_3344});
    beat(HDR4, 1, 0, 0);
    beat(64'h0000_0000_0000_0088, 0, 0, 0);
    beat(64'hAABB_CCDD_0102_0304, 0, 1, 0);
    check("post_dsc_addr1", hp_addr, {64'h0403_0201_DDCC_BBAA, 64'h5566_7788_1122_3344});

    // Stalls between beats, including a dst-not-ready cycle carrying EOF
    beat(HDR3, 1, 0, 0);
    idle(3);
    beat(64'hF000_0080_DEAD_BEEF, 0, 0, 0);
    idle(3);
    trn_rdst_rdy_n = 1'b1;
    trn_rsrc_rdy_n = 1'b0;
    trn_reof_n     = 1'b0;
    trn_rd         = 64'h1234_5678_9ABC_DEF0;
    idle(1);
    trn_rsrc_rdy_n = 1'b1;
    trn_reof_n     = 1'b1;
    trn_rdst_rdy_n = 1'b0;
    check("stall_mid", hp_addr, {64'h0403_0201_DDCC_BBAA, 64'h5566_7788_1122_3344});
    beat(64'hCAFE_F00D_0000_0000, 0, 1, 0);
    check("stall_addr0", hp_addr, {64'h0403_0201_DDCC_BBAA, 64'h0DF0_FECA_EFBE_ADDE});

    // BAR0-only hit is ignored
    trn_rbar_hit_n = 7'b111_1110;
    beat(HDR3_1, 1, 0, 0);
    beat(64'hF000_00A4_5000_0000, 0, 1, 0);
    trn_rbar_hit_n = 7'b111_1011;
    check("bar0_ready", {126'h0, hp_ready}, 128'h0);
    check("bar0_qwords", {64'h0, hp_qwords}, {64'h0, 64'h0000_1000_0000_0030});

    // Miss TLP drained; payload beat resembling a header must not start a decode
    beat(HDR3, 1, 0, 0);
    beat(64'hF000_0028_0000_0000, 0, 0, 0);
    beat(HDR3_1, 0, 0, 0);
    beat(64'hF000_00A0_7700_0000, 0, 1, 0);
    check("drain_ready", {126'h0, hp_ready}, 128'h0);
    beat(HDR3_1, 1, 0, 0);
    beat(64'hF000_00A4_4000_0000, 0, 1, 0);
    check("after_drain_qw1", {64'h0, hp_qwords}, {64'h0, 64'h0000_0040_0000_0030});
    check("after_drain_ready", {126'h0, hp_ready}, {126'h0, 2'b10});
    check("after_drain_cnt", {112'h0, unlock_overrun_cnt}, {112'h0, 16'd2});

    // Reset in the middle of an address write; tail beat must be ignored
    beat(HDR3, 1, 0, 0);
    beat(64'hF000_0080_1234_5678, 0, 0, 0);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    beat(64'h9999_9999_0000_0000, 0, 1, 0);
    check("rst_mid_addr", hp_addr, 128'h0);
    check("rst_mid_ready", {126'h0, hp_ready}, 128'h0);
    check("rst_mid_cnt", {112'h0, unlock_overrun_cnt}, 128'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
